// File: rtl/seq_mul_pkg.sv
// Shared types, constants and helpers for the sequential shift-add multiplier.
// SEQ_MUL_SIGNED_EN selects the two's-complement (radix-2 Booth) build.
package seq_mul_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Booth recoding of {q0, q_m1}; 2'b11 also means no operation
    localparam logic [1:0] BOOTH_NOP = 2'b00;
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// start/ready handshake bundle between the datapath controller and the multiplier.
// The controller drives the master side; the multiplier is the slave.
interface seq_multiplier_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               ready;
    logic [2*WIDTH-1:0] product;

    modport master (
        output start, a, b,
        input  ready, product
    );

    modport slave (
        input  start, a, b,
        output ready, product
    );
endinterface

// File: rtl/seq_mul_datapath.sv
// Multiplicand register, guarded accumulator, add/sub and one-bit shifter.
// SEQ_MUL_SIGNED_EN adds the Booth bit and the subtract path.
module seq_mul_datapath
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] next_product
);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH:0]   upper_q;
    logic [WIDTH-1:0] lower_q;
    logic [WIDTH:0]   upper_d;
    logic [WIDTH-1:0] lower_d;
    logic [WIDTH:0]   sum;

`ifdef SEQ_MUL_SIGNED_EN
    logic           q_m1_q;
    logic           q_m1_d;
    logic [WIDTH:0] mcand_ext;

    assign mcand_ext = {mcand_q[WIDTH-1], mcand_q};

    // Booth add/sub on the upper part, then arithmetic shift right
    always_comb begin
        sum = upper_q;
        case ({lower_q[0], q_m1_q})
            BOOTH_ADD: sum = upper_q + mcand_ext;
            BOOTH_SUB: sum = upper_q - mcand_ext;
            BOOTH_NOP: sum = upper_q;
            default:   sum = upper_q;
        endcase
        upper_d = {sum[WIDTH], sum[WIDTH:1]};
        lower_d = {sum[0], lower_q[WIDTH-1:1]};
        q_m1_d  = lower_q[0];
    end

    // Booth bit register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_m1_q <= 1'b0;
        end else if (load) begin
            q_m1_q <= 1'b0;
        end else if (step) begin
            q_m1_q <= q_m1_d;
        end
    end
`else
    // Conditional add of the multiplicand, then logical shift right
    always_comb begin
        sum = upper_q;
        if (lower_q[0]) begin
            sum = upper_q + {1'b0, mcand_q};
        end
        upper_d = {1'b0, sum[WIDTH:1]};
        lower_d = {sum[0], lower_q[WIDTH-1:1]};
    end
`endif

    // Operand capture on accept, one iteration per busy cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q <= '0;
            upper_q <= '0;
            lower_q <= '0;
        end else if (load) begin
            mcand_q <= a;
            upper_q <= '0;
            lower_q <= b;
        end else if (step) begin
            upper_q <= upper_d;
            lower_q <= lower_d;
        end
    end

    // Value the accumulator takes after the current iteration
    assign next_product = {upper_d[WIDTH-1:0], lower_d};

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier behind a start/ready handshake.
// SEQ_MUL_SIGNED_EN selects signed Booth operation; default is unsigned.
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    seq_multiplier_if.slave bus
);

    localparam int             CW   = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t               state_q;
    state_t               state_d;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   product_q;
    logic [2*WIDTH-1:0]   next_product;
    logic                 load;
    logic                 step;
    logic                 done;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath controls; start is ignored while busy
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt_q == LAST) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Iteration counter and held result, loaded only on completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            if (load || done) begin
                cnt_q <= '0;
            end else if (step) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (done) begin
                product_q <= next_product;
            end
        end
    end

    seq_mul_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .step         (step),
        .a            (bus.a),
        .b            (bus.b),
        .next_product (next_product)
    );

    assign bus.ready   = (state_q == IDLE);
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (WIDTH=8), unsigned or signed build.
module tb_seq_multiplier;

    localparam int W = 8;

    logic clk;
    logic rst;
    int   cyc;
    int   acc_cyc;
    int   checks;
    int   errors;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_prod;

    seq_multiplier_if #(.WIDTH(W)) bus ();

    seq_multiplier #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x,
                                             input logic [W-1:0] y);
`ifdef SEQ_MUL_SIGNED_EN
        logic signed [2*W-1:0] sx;
        logic signed [2*W-1:0] sy;
        sx = {{W{x[W-1]}}, x};
        sy = {{W{y[W-1]}}, y};
        return sx * sy;
`else
        logic [2*W-1:0] ux;
        logic [2*W-1:0] uy;
        ux = {{W{1'b0}}, x};
        uy = {{W{1'b0}}, y};
        return ux * uy;
`endif
    endfunction

    // Called at a negedge with ready=1; start is left high
    task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y);
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        exp_q.push_back(model(x, y));
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        check("busy_after_accept", 32'(bus.ready), 32'd0);
    endtask

    task automatic finish_op(input string tag);
        int n;
        logic [2*W-1:0] e;
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.ready !== 1'b1) begin
                check({tag, "_held"}, 32'(bus.product), 32'(last_prod));
            end
        end
        if (bus.ready !== 1'b1) begin
            check({tag, "_timeout"}, 32'(bus.ready), 32'd1);
            return;
        end
        check({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(W));
        if (exp_q.size() == 0) begin
            check({tag, "_no_expect"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check(tag, 32'(bus.product), 32'(e));
        last_prod = bus.product;
    endtask

    task automatic run(input string tag, input logic [W-1:0] x,
                       input logic [W-1:0] y);
        accept(x, y);
        bus.start = 1'b0;
        finish_op(tag);
    endtask

    initial begin
        int c1;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        acc_cyc   = 0;
        last_prod = '0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_product", 32'(bus.product), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready", 32'(bus.ready), 32'd1);
        check("idle_product", 32'(bus.product), 32'd0);

`ifdef SEQ_MUL_SIGNED_EN
        run("s_7_m3", 8'd7, 8'hFD);
        check("s_7_m3_const", 32'(last_prod), 32'h0000FFEB);
        run("s_min_min", 8'h80, 8'h80);
        check("s_min_min_const", 32'(last_prod), 32'h00004000);
        run("s_m1_max", 8'hFF, 8'h7F);
`else
        run("u_255_255", 8'd255, 8'd255);
        check("u_255_255_const", 32'(last_prod), 32'h0000FE01);
        run("u_0_200", 8'd0, 8'd200);
        check("u_0_200_const", 32'(last_prod), 32'h00000000);
        run("u_128_2", 8'd128, 8'd2);
`endif

        repeat (3) @(negedge clk);
        check("idle_hold", 32'(bus.product), 32'(last_prod));

        // start pulsed mid-operation must be ignored
        accept(8'd3, 8'd5);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.a     = 8'd9;
        bus.b     = 8'd9;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        finish_op("busy_start");
        check("busy_start_const", 32'(last_prod), 32'h0000000F);

        // asynchronous abort in the middle of an operation
        accept(8'd6, 8'd7);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_product", 32'(bus.product), 32'd0);
        exp_q.delete();
        last_prod = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run("after_abort", 8'd2, 8'd2);
        check("after_abort_const", 32'(last_prod), 32'h00000004);

        // back-to-back with start held high
        accept(8'd11, 8'd13);
        bus.a = 8'd17;
        bus.b = 8'd19;
        finish_op("b2b_first");
        c1 = cyc;
        accept(8'd17, 8'd19);
        bus.start = 1'b0;
        finish_op("b2b_second");
        check("b2b_spacing", 32'(cyc - c1), 32'(W + 1));

        for (int i = 0; i < 6; i++) begin
            run("rand", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
